// File: rtl/axi_pkg.sv
// Shared AXI encodings and the cache-to-AXI bridge state type.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } bridge_state_t;

  // AXI size encoding is log2 of the bytes per beat; non-powers of two map to 0.
  function automatic logic [2:0] size_from_bytes(input int unsigned bytes);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bytes == (32'd1 << i)) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/axi_mem_bridge.sv
// Bridges the cache controller's req/rdy memory port onto an AXI4 master.
// One outstanding transaction; every AXI output comes straight from a register.
module axi_mem_bridge
  import axi_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 10,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    DATA_SIZE_BYTES = 4,
  parameter int                    ID_WIDTH        = 4,
  parameter logic [ID_WIDTH-1:0]   AXI_ID          = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_req,
  input  logic [ADDR_WIDTH-1:0]      i_addr,
  input  logic                       i_wen,
  input  logic [DATA_SIZE_BYTES-1:0] i_ben,
  input  logic [7:0]                 i_len,
  input  logic [DATA_WIDTH-1:0]      i_data,
  output logic                       o_rdy,
  output logic                       o_valid,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic                       o_err,
  output logic                       m_awvalid,
  input  logic                       m_awready,
  output logic [ADDR_WIDTH-1:0]      m_awaddr,
  output logic [7:0]                 m_awlen,
  output logic [2:0]                 m_awsize,
  output logic [1:0]                 m_awburst,
  output logic [ID_WIDTH-1:0]        m_awid,
  output logic                       m_wvalid,
  input  logic                       m_wready,
  output logic [DATA_WIDTH-1:0]      m_wdata,
  output logic [DATA_SIZE_BYTES-1:0] m_wstrb,
  output logic                       m_wlast,
  input  logic                       m_bvalid,
  output logic                       m_bready,
  input  logic [1:0]                 m_bresp,
  output logic                       m_arvalid,
  input  logic                       m_arready,
  output logic [ADDR_WIDTH-1:0]      m_araddr,
  output logic [7:0]                 m_arlen,
  output logic [2:0]                 m_arsize,
  output logic [1:0]                 m_arburst,
  output logic [ID_WIDTH-1:0]        m_arid,
  input  logic                       m_rvalid,
  output logic                       m_rready,
  input  logic [DATA_WIDTH-1:0]      m_rdata,
  input  logic [1:0]                 m_rresp,
  input  logic                       m_rlast
);

  bridge_state_t state_reg, state_next;
  logic [ADDR_WIDTH-1:0]      addr_reg, addr_next;
  logic [DATA_SIZE_BYTES-1:0] ben_reg, ben_next;
  logic [7:0]                 len_reg, len_next;
  logic [DATA_WIDTH-1:0]      data_reg, data_next;
  logic [8:0]                 beat_reg, beat_next;
  logic                       rdy_reg, rdy_next;
  logic                       arvalid_reg, arvalid_next;
  logic                       rready_reg, rready_next;
  logic                       awvalid_reg, awvalid_next;
  logic                       wvalid_reg, wvalid_next;
  logic                       bready_reg, bready_next;
  logic                       aw_done_reg, aw_done_next;
  logic                       w_done_reg, w_done_next;
  logic                       valid_reg, valid_next;
  logic [DATA_WIDTH-1:0]      rdata_reg, rdata_next;
  logic                       err_reg, err_next;

  // Only bit 1 of a response (SLVERR/DECERR) signals an error.
  logic unused_resp_lsb;
  assign unused_resp_lsb = m_rresp[0] ^ m_bresp[0];

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    ben_next     = ben_reg;
    len_next     = len_reg;
    data_next    = data_reg;
    beat_next    = beat_reg;
    rdy_next     = rdy_reg;
    arvalid_next = arvalid_reg;
    rready_next  = rready_reg;
    awvalid_next = awvalid_reg;
    wvalid_next  = wvalid_reg;
    bready_next  = bready_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    valid_next   = 1'b0;
    rdata_next   = rdata_reg;
    err_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        rdy_next = 1'b1;
        if (i_req && rdy_reg) begin
          addr_next = i_addr;
          ben_next  = i_ben;
          len_next  = i_len;
          data_next = i_data;
          rdy_next  = 1'b0;
          if (i_wen) begin
            state_next   = WR_REQ;
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            aw_done_next = 1'b0;
            w_done_next  = 1'b0;
          end else begin
            state_next   = RD_ADDR;
            arvalid_next = 1'b1;
          end
        end
      end
      RD_ADDR: begin
        if (arvalid_reg && m_arready) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          beat_next    = 9'd0;
          state_next   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_rvalid && rready_reg) begin
          valid_next = 1'b1;
          rdata_next = m_rdata;
          // Saturate so very long over-runs never alias back onto len.
          beat_next  = (beat_reg == 9'h1FF) ? beat_reg : beat_reg + 9'd1;
          err_next   = m_rresp[1] ||
                       (m_rlast  && (beat_reg != {1'b0, len_reg})) ||
                       (!m_rlast && (beat_reg == {1'b0, len_reg}));
          if (m_rlast) begin
            rready_next = 1'b0;
            rdy_next    = 1'b1;
            state_next  = IDLE;
          end
        end
      end
      WR_REQ: begin
        // AW and W retire independently; each valid drops after its own ready.
        if (awvalid_reg && m_awready) begin
          awvalid_next = 1'b0;
          aw_done_next = 1'b1;
        end
        if (wvalid_reg && m_wready) begin
          wvalid_next = 1'b0;
          w_done_next = 1'b1;
        end
        if (aw_done_next && w_done_next) begin
          bready_next = 1'b1;
          state_next  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_bvalid && bready_reg) begin
          bready_next = 1'b0;
          err_next    = m_bresp[1];
          rdy_next    = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      ben_reg     <= '0;
      len_reg     <= '0;
      data_reg    <= '0;
      beat_reg    <= '0;
      rdy_reg     <= 1'b0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      valid_reg   <= 1'b0;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      ben_reg     <= ben_next;
      len_reg     <= len_next;
      data_reg    <= data_next;
      beat_reg    <= beat_next;
      rdy_reg     <= rdy_next;
      arvalid_reg <= arvalid_next;
      rready_reg  <= rready_next;
      awvalid_reg <= awvalid_next;
      wvalid_reg  <= wvalid_next;
      bready_reg  <= bready_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
      valid_reg   <= valid_next;
      rdata_reg   <= rdata_next;
      err_reg     <= err_next;
    end
  end

  assign o_rdy     = rdy_reg;
  assign o_valid   = valid_reg;
  assign o_data    = rdata_reg;
  assign o_err     = err_reg;

  assign m_awvalid = awvalid_reg;
  assign m_awaddr  = addr_reg;
  assign m_awlen   = 8'd0;
  assign m_awsize  = size_from_bytes(DATA_SIZE_BYTES);
  assign m_awburst = BURST_INCR;
  assign m_awid    = AXI_ID;
  assign m_wvalid  = wvalid_reg;
  assign m_wdata   = data_reg;
  assign m_wstrb   = ben_reg;
  assign m_wlast   = 1'b1;
  assign m_bready  = bready_reg;

  assign m_arvalid = arvalid_reg;
  assign m_araddr  = addr_reg;
  assign m_arlen   = len_reg;
  assign m_arsize  = size_from_bytes(DATA_SIZE_BYTES);
  assign m_arburst = BURST_INCR;
  assign m_arid    = AXI_ID;
  assign m_rready  = rready_reg;

endmodule

// File: doc/axi_mem_bridge.md
Name: axi_mem_bridge

Overview:
- Sits directly downstream of the cache controller's memory port: takes its req/rdy line-fill and write-through requests and issues them as AXI4 master transactions.
- Read beats return on a valid/data strobe, one beat per cycle.
- Writes are single-beat; the bridge reports completion only after the B response.
- One outstanding transaction at a time; no reordering, no IDs beyond a fixed constant.

Parameters:
- ADDR_WIDTH, 10, byte address width on both sides.
- DATA_WIDTH, 32, data bus width.
- DATA_SIZE_BYTES, 4, byte enables per beat; AXI size = log2(DATA_SIZE_BYTES).
- ID_WIDTH, 4, AXI ID width.
- AXI_ID, 0, constant value driven on awid/arid.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  request from cache controller; held until accepted.
- i_addr  in  ADDR_WIDTH  word-aligned start address.
- i_wen  in  1  1 = write, 0 = read.
- i_ben  in  DATA_SIZE_BYTES  write byte enables.
- i_len  in  8  read beats minus 1; ignored for writes.
- i_data  in  DATA_WIDTH  write data.
- o_rdy  out  1  idle and able to accept.
- o_valid  out  1  one read beat on o_data this cycle.
- o_data  out  DATA_WIDTH  read beat data.
- o_err  out  1  single-cycle pulse on error response or burst-length mismatch.
- m_awvalid/m_awready, m_awaddr[ADDR_WIDTH], m_awlen[8], m_awsize[3], m_awburst[2], m_awid[ID_WIDTH]: AXI write address channel.
- m_wvalid/m_wready, m_wdata[DATA_WIDTH], m_wstrb[DATA_SIZE_BYTES], m_wlast: AXI write data channel.
- m_bvalid in, m_bready out, m_bresp[2] in: AXI write response channel.
- m_arvalid/m_arready, m_araddr, m_arlen, m_arsize, m_arburst, m_arid: AXI read address channel.
- m_rvalid in, m_rready out, m_rdata[DATA_WIDTH] in, m_rresp[2] in, m_rlast in: AXI read data channel.

Behaviour:
- Reset (reset=1 at a clk edge): state IDLE.
  - All valid/ready outputs 0; o_rdy, o_valid and o_err are 0.
  - All address, data and len registers are 0.
  - o_rdy is forced 0 while reset is high and rises the first cycle after reset falls.
- Accept: a request is accepted when i_req && o_rdy at an edge.
  - addr, wen, ben, len and data are captured into registers.
  - o_rdy drops the next cycle and stays 0 until the transaction completes.
- Fixed AXI fields: burst INCR (2'b01), size log2(DATA_SIZE_BYTES), id AXI_ID. awlen=0 and wlast=1 for every write.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE:
  - Read accepted -> RD_ADDR with arvalid=1, araddr/arlen from the captured request.
  - Write accepted -> WR_REQ with awvalid=1 and wvalid=1 asserted in the same cycle.
- RD_ADDR: arvalid held with all AR fields stable until arready. Then arvalid=0, rready=1, -> RD_DATA.
- RD_DATA: rready held 1. Each rvalid beat is registered: o_valid=1 and o_data=rdata one cycle after the handshake.
  - A beat counter starts at 0 and increments per beat.
  - On the rlast beat: rready=0 and the FSM -> IDLE. o_rdy rises in the same cycle as the final o_valid.
- WR_REQ: AW and W complete independently, in either order or in the same cycle.
  - Each valid drops the cycle after its own ready; sticky done flags record completion.
  - When both are done -> WR_RESP with bready=1.
- WR_RESP: on bvalid, bready=0 and -> IDLE. o_rdy=1 the next cycle.
- o_err pulses one cycle, at the same time as the affected o_valid or at the transition to IDLE, when any of these occurs:
  - rresp[1]=1 on any beat;
  - bresp[1]=1;
  - rlast arrives with beat counter != captured len;
  - counter reaches len without rlast.
  - In the last case the bridge keeps accepting beats until rlast. Beats beyond len+1 still drive o_valid.
- Stability: AXI outputs and o_data change only on an edge and never change while their valid is high and ready is low.
- Timing: no combinational path from any m_* input to any m_* output or to o_rdy.
- Reset mid-transaction: FSM returns to IDLE immediately and all valids drop.
  - Any AXI handshake in progress is abandoned; the system resets the slave together with the bridge.
- Minimum latency:
  - Read: accept at N, arvalid at N+1; with arready=1 and rvalid=1 in the same cycle, the first o_valid is at N+3.
  - Write: accept at N, aw/w at N+1, bready at N+2, o_rdy at N+3 with bvalid=1.

Decomposition:
- Shared package axi_pkg holds:
  - burst codes (FIXED/INCR/WRAP);
  - resp codes (OKAY/EXOKAY/SLVERR/DECERR);
  - the bridge_state_t enum;
  - function size_from_bytes(bytes).
- No sub-module is needed. The AW/W independent-handshake tracking stays inline as two sticky flags.

Test Plan:
- Read burst: req addr 0x040, len 3, slave returns 0xA0..0xA3 with rlast on 4th beat -> arlen=3, araddr=0x040, four o_valid with A0..A3 in order, o_rdy rises with the last o_valid, o_err=0.
- Write: addr 0x07C, ben 4'b0110, data 0xDEADBEEF -> awaddr=0x07C, wstrb=0110, wlast=1, awlen=0; o_rdy stays 0 until bvalid, then 1.
- Skewed write: awready 3 cycles after wready, bvalid 2 cycles later -> wvalid drops after its handshake, awvalid held, no duplicate beats, single completion.
- Errors: rresp=SLVERR on beat 1 of a len-1 read -> o_err on that beat's o_valid, both beats delivered. Separately, rlast on beat 2 of a len-3 read -> o_err and return to IDLE.
- Backpressure: arready low 5 cycles, rvalid toggling 1/0 -> araddr/arlen stable while waiting, o_valid only on handshake cycles.
- Reset mid-RD_DATA after beat 1 -> all valids 0 next cycle, no further o_valid; a fresh read of 0x000 len 0 then completes normally.
